branch_predictor: RTL

Fetch-side partner of the ID-stage branch comparator. Predicts taken/not-taken and the target for conditional branches (opcodes 0x06–0x0B) at IF using a direct-mapped branch target buffer with 2-bit saturating counters. At ID it consumes the comparator's resolved outcome, raises a redirect and IF flush on misprediction, and trains the table.

---
 rtl/branch_predictor_pkg.sv | 37 +++
 rtl/branch_predictor_btb_storage.sv | 66 ++++++
 rtl/branch_predictor.sv | 96 +++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared branch definitions: opcodes, 2-bit counter encodings and table update commands.
package branch_predictor_pkg;

    localparam logic [5:0] OP_BEQ = 6'h06;
    localparam logic [5:0] OP_BNE = 6'h07;
    localparam logic [5:0] OP_BGE = 6'h08;
    localparam logic [5:0] OP_BGT = 6'h09;
    localparam logic [5:0] OP_BLE = 6'h0A;
    localparam logic [5:0] OP_BLT = 6'h0B;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic [1:0] {
        UPD_NONE      = 2'd0,
        UPD_TAKEN     = 2'd1,
        UPD_NOT_TAKEN = 2'd2,
        UPD_INVAL     = 2'd3
    } upd_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BLT);
    endfunction

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_btb_storage.sv
// Direct-mapped BTB arrays: async lookup port, and a command-style write port that
// does its own read-modify-write of the addressed entry (hit test included).
module btb_storage
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [31:0]       rd_target_o,
    output ctr_e              rd_ctr_o,
    input  upd_e              upd_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [31:0]       wr_target_i
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    ctr_e             ctr_q    [DEPTH];
    logic             wr_hit;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

    // Tag/target need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else begin
            case (upd_i)
                UPD_TAKEN: begin
                    target_q[wr_idx_i] <= wr_target_i;
                    if (wr_hit) begin
                        ctr_q[wr_idx_i] <= ctr_inc(ctr_q[wr_idx_i]);
                    end else begin
                        valid_q[wr_idx_i] <= 1'b1;
                        tag_q[wr_idx_i]   <= wr_tag_i;
                        ctr_q[wr_idx_i]   <= CTR_WT;
                    end
                end
                UPD_NOT_TAKEN: begin
                    if (wr_hit) ctr_q[wr_idx_i] <= ctr_dec(ctr_q[wr_idx_i]);
                end
                UPD_INVAL: begin
                    if (wr_hit) valid_q[wr_idx_i] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage BTB prediction plus ID-stage misprediction detection, redirect and training.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        id_valid_i,
    input  logic [5:0]  id_opcode_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_target_i,
    input  logic        id_taken_i,
    input  logic        id_pred_taken_i,
    input  logic [31:0] id_pred_target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_if_o,
    output logic [31:0] mispredict_cnt_o
);
    localparam int TAG_W = 30 - IDX_W;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_target;
    ctr_e              rd_ctr;
    logic              if_hit;
    logic              id_is_br;
    upd_e              upd;
    logic [31:0]       cnt_q, cnt_d;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc_i[1:0], id_pc_i[1:0]};

    btb_storage #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (if_pc_i[IDX_W+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_target_o(rd_target),
        .rd_ctr_o   (rd_ctr),
        .upd_i      (upd),
        .wr_idx_i   (id_pc_i[IDX_W+1:2]),
        .wr_tag_i   (id_pc_i[31:IDX_W+2]),
        .wr_target_i(id_target_i)
    );

    assign if_hit        = rd_valid && (rd_tag == if_pc_i[31:IDX_W+2]);
    assign pred_taken_o  = if_hit && rd_ctr[1];
    assign pred_target_o = pred_taken_o ? rd_target : if_pc_i + 32'd4;

    assign id_is_br = id_valid_i && is_branch(id_opcode_i);

    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = id_pc_i + 32'd4;
        if (!reset && id_valid_i) begin
            if (id_is_br) begin
                // A taken branch redirects unless predicted taken to the same target.
                if (id_taken_i && (!id_pred_taken_i || id_pred_target_i != id_target_i)) begin
                    redirect_o    = 1'b1;
                    redirect_pc_o = id_target_i;
                end else if (!id_taken_i && id_pred_taken_i) begin
                    redirect_o = 1'b1;
                end
            end else if (id_pred_taken_i) begin
                redirect_o = 1'b1;
            end
        end
    end

    assign flush_if_o = redirect_o;

    always_comb begin
        upd = UPD_NONE;
        if (id_valid_i) begin
            if (!id_is_br)      upd = UPD_INVAL;
            else if (id_taken_i) upd = UPD_TAKEN;
            else                upd = UPD_NOT_TAKEN;
        end
    end

    assign cnt_d = (redirect_o && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign mispredict_cnt_o = cnt_q;

endmodule
